// File: rtl/fxp_div_pkg.sv
// Shared types and constants for the shared fixed-point divider arbiter.
// Holds the FSM state encoding, the requester grant vectors and sizing helpers.
package fxp_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_FRAC  = 4;
  localparam int DEF_N     = DEF_WIDTH + DEF_FRAC;

  localparam logic [1:0] REQ_NONE = 2'b00;
  localparam logic [1:0] REQ_0    = 2'b01;
  localparam logic [1:0] REQ_1    = 2'b10;
  localparam logic [1:0] REQ_BOTH = 2'b11;

  // Bit-counter width able to hold the value n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fxp_udiv_step.sv
// One restoring long-division step: shift the next dividend bit into the
// remainder, subtract the divisor when it fits, and emit that quotient bit.
module fxp_udiv_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted  = {rem, bit_in};
    diff     = shifted - {2'b00, divisor};
    q_bit    = (shifted >= {2'b00, divisor});
    // The remainder stays below the divisor, so WIDTH+1 bits always suffice.
    rem_next = (WIDTH+1)'(q_bit ? diff : shifted);
  end

endmodule

// File: rtl/fxp_udiv_arbiter.sv
// Two-requester round-robin front end for a shared bit-serial unsigned
// fixed-point divider, returning saturated quotients over valid/ready.
module fxp_udiv_arbiter
  import fxp_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [1:0]       i_req_valid,
  output logic [1:0]       o_req_ready,
  input  logic [WIDTH-1:0] i_dividend0,
  input  logic [WIDTH-1:0] i_divisor0,
  input  logic [WIDTH-1:0] i_dividend1,
  input  logic [WIDTH-1:0] i_divisor1,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic             o_rsp_id,
  output logic [WIDTH-1:0] o_rsp_quot,
  output logic             o_rsp_dbz,
  output logic             o_rsp_ovf,
  output logic             o_busy
);

  localparam int N     = WIDTH + FRAC;
  localparam int CNT_W = cnt_width(N);
  localparam logic [N-1:0]     QMAX     = N'({WIDTH{1'b1}});
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  state_t           state_reg, state_next;
  logic             last_grant_reg;
  logic [1:0]       grant;
  logic [WIDTH-1:0] sel_dividend, sel_divisor;

  logic [N-1:0]     ext_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic [WIDTH:0]   rem_reg, rem_next;
  logic [N-1:0]     quot_reg, quot_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             q_bit;

  logic             id_reg, dbz_reg, ovf_reg;
  logic [WIDTH-1:0] rsp_quot_reg;

  fxp_udiv_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_reg),
    .bit_in   (ext_reg[N-1]),
    .divisor  (divisor_reg),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign quot_next = (quot_reg << 1) | N'(q_bit);

  always_comb begin
    grant = REQ_NONE;
    if (state_reg == IDLE) begin
      case (i_req_valid)
        REQ_0:    grant = REQ_0;
        REQ_1:    grant = REQ_1;
        REQ_BOTH: grant = last_grant_reg ? REQ_0 : REQ_1;
        default:  grant = REQ_NONE;
      endcase
    end
    sel_dividend = grant[1] ? i_dividend1 : i_dividend0;
    sel_divisor  = grant[1] ? i_divisor1  : i_divisor0;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (grant != REQ_NONE) state_next = (sel_divisor == '0) ? DONE : ITER;
      ITER: if (cnt_reg == LAST_CNT) state_next = DONE;
      DONE: if (i_rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      ext_reg        <= '0;
      divisor_reg    <= '0;
      rem_reg        <= '0;
      quot_reg       <= '0;
      cnt_reg        <= '0;
      id_reg         <= 1'b0;
      dbz_reg        <= 1'b0;
      ovf_reg        <= 1'b0;
      rsp_quot_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (grant != REQ_NONE) begin
            id_reg         <= grant[1];
            last_grant_reg <= grant[1];
            divisor_reg    <= sel_divisor;
            ext_reg        <= N'(sel_dividend) << FRAC;
            rem_reg        <= '0;
            quot_reg       <= '0;
            cnt_reg        <= '0;
            if (sel_divisor == '0) begin
              rsp_quot_reg <= '1;
              dbz_reg      <= 1'b1;
              ovf_reg      <= 1'b0;
            end
          end
        end
        ITER: begin
          rem_reg  <= rem_next;
          quot_reg <= quot_next;
          ext_reg  <= ext_reg << 1;
          cnt_reg  <= cnt_reg + 1'b1;
          // Result registers are loaded once, on the final step, so they stay frozen in DONE.
          if (cnt_reg == LAST_CNT) begin
            dbz_reg      <= 1'b0;
            ovf_reg      <= (quot_next > QMAX);
            rsp_quot_reg <= (quot_next > QMAX) ? '1 : quot_next[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign o_req_ready = grant;
  assign o_rsp_valid = (state_reg == DONE);
  assign o_busy      = (state_reg != IDLE);
  assign o_rsp_id    = id_reg;
  assign o_rsp_quot  = rsp_quot_reg;
  assign o_rsp_dbz   = dbz_reg;
  assign o_rsp_ovf   = ovf_reg;

endmodule
